// File: rtl/fproc_arb_pkg.sv
// Shared types and helpers for the fproc request arbiter and its round-robin picker.
package fproc_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Index width that never collapses to zero bits for a single-entry vector.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fproc_rr_arbiter_if.sv
// Per-core request/response bus plus the single fproc channel seen by the arbiter.
interface fproc_rr_arbiter_if #(
    parameter int N_CORES    = 4,
    parameter int ID_WIDTH   = 8,
    parameter int DATA_WIDTH = 32
);
    logic [N_CORES-1:0]          core_req_en;
    logic [N_CORES*ID_WIDTH-1:0] core_req_id;
    logic [N_CORES-1:0]          core_ready;
    logic [DATA_WIDTH-1:0]       core_data;
    logic                        fproc_req_en;
    logic [ID_WIDTH-1:0]         fproc_req_id;
    logic                        fproc_ack;
    logic [DATA_WIDTH-1:0]       fproc_data;
    logic                        busy;
    logic                        req_overflow;

    // master: the arbiter itself; slave: the cores and fproc around it.
    modport master (
        input  core_req_en, core_req_id, fproc_ack, fproc_data,
        output core_ready, core_data, fproc_req_en, fproc_req_id, busy, req_overflow
    );

    modport slave (
        output core_req_en, core_req_id, fproc_ack, fproc_data,
        input  core_ready, core_data, fproc_req_en, fproc_req_id, busy, req_overflow
    );
endinterface

// File: rtl/fproc_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit strictly after ptr, wrapping modulo N.
module rr_pick
    import fproc_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  pending,
    input  logic [IW-1:0] ptr,
    output logic          valid,
    output logic [IW-1:0] idx
);
    always_comb begin
        int c;
        valid = 1'b0;
        idx   = '0;
        c     = 0;
        for (int k = 1; k <= N; k++) begin
            c = (int'(ptr) + k) % N;
            if (!valid && pending[c]) begin
                valid = 1'b1;
                idx   = IW'(c);
            end
        end
    end
endmodule

// File: rtl/fproc_rr_arbiter.sv
// Latches one-cycle fproc requests from N cores and serialises them to fproc round-robin,
// returning each response to its owner with a one-cycle ready pulse.
module fproc_rr_arbiter
    import fproc_arb_pkg::*;
#(
    parameter int N_CORES    = 4,
    parameter int ID_WIDTH   = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    fproc_rr_arbiter_if.master    bus
);
    localparam int IW = idx_width(N_CORES);

    state_t                 state_reg, state_next;
    logic [IW-1:0]          grant_reg, grant_next;
    logic [IW-1:0]          rr_ptr_reg, rr_ptr_next;
    logic [DATA_WIDTH-1:0]  data_q_reg, data_q_next;
    logic [N_CORES-1:0]     pending_reg;
    logic [ID_WIDTH-1:0]    id_q_reg [N_CORES];
    logic                   overflow_reg;
    logic [N_CORES-1:0]     clr_vec;
    logic                   pick_valid;
    logic [IW-1:0]          pick_idx;

    // The RESP one-hot doubles as the pending-clear vector and the core_ready output.
    generate
        for (genvar gi = 0; gi < N_CORES; gi++) begin : g_clr
            assign clr_vec[gi] = (state_reg == RESP) && (grant_reg == IW'(gi));
        end
    endgenerate

    // A new request in the clearing cycle wins, so it is neither lost nor an overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_reg  <= '0;
            overflow_reg <= 1'b0;
            for (int i = 0; i < N_CORES; i++) id_q_reg[i] <= '0;
        end else begin
            if (|(bus.core_req_en & pending_reg & ~clr_vec)) overflow_reg <= 1'b1;
            for (int i = 0; i < N_CORES; i++) begin
                if (bus.core_req_en[i]) begin
                    pending_reg[i] <= 1'b1;
                    id_q_reg[i]    <= bus.core_req_id[i*ID_WIDTH +: ID_WIDTH];
                end else if (clr_vec[i]) begin
                    pending_reg[i] <= 1'b0;
                end
            end
        end
    end

    rr_pick #(.N(N_CORES), .IW(IW)) u_pick (
        .pending (pending_reg),
        .ptr     (rr_ptr_reg),
        .valid   (pick_valid),
        .idx     (pick_idx)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            grant_reg  <= '0;
            rr_ptr_reg <= IW'(N_CORES - 1);
            data_q_reg <= '0;
        end else begin
            state_reg  <= state_next;
            grant_reg  <= grant_next;
            rr_ptr_reg <= rr_ptr_next;
            data_q_reg <= data_q_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        grant_next  = grant_reg;
        rr_ptr_next = rr_ptr_reg;
        data_q_next = data_q_reg;
        case (state_reg)
            IDLE: begin
                if (pick_valid) begin
                    grant_next = pick_idx;
                    state_next = ISSUE;
                end
            end
            ISSUE: state_next = WAIT;
            WAIT: begin
                if (bus.fproc_ack) begin
                    data_q_next = bus.fproc_data;
                    state_next  = RESP;
                end
            end
            RESP: begin
                rr_ptr_next = grant_reg;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.fproc_req_en = (state_reg == ISSUE);
    assign bus.fproc_req_id = (state_reg == ISSUE) ? id_q_reg[grant_reg] : '0;
    assign bus.core_ready   = clr_vec;
    assign bus.core_data    = (state_reg == RESP) ? data_q_reg : '0;
    assign bus.busy         = (state_reg != IDLE);
    assign bus.req_overflow = overflow_reg;

endmodule

// File: tb/tb_fproc_rr_arbiter.sv
// Directed bench for fproc_rr_arbiter: latency, round-robin order, re-request and overflow, reset abort.
module tb_fproc_rr_arbiter;
    localparam int N   = 4;
    localparam int IDW = 8;
    localparam int DW  = 32;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    always #5 clk = ~clk;

    fproc_rr_arbiter_if #(.N_CORES(N), .ID_WIDTH(IDW), .DATA_WIDTH(DW)) bus ();

    fproc_rr_arbiter #(.N_CORES(N), .ID_WIDTH(IDW), .DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_req(input int core, input logic [IDW-1:0] id);
        bus.core_req_en[core]           = 1'b1;
        bus.core_req_id[core*IDW +: IDW] = id;
    endtask

    task automatic clr_req();
        bus.core_req_en = '0;
    endtask

    task automatic do_reset(input string tag);
        reset           = 1'b1;
        bus.core_req_en = '0;
        bus.core_req_id = '0;
        bus.fproc_ack   = 1'b0;
        bus.fproc_data  = '0;
        tick();
        tick();
        reset = 1'b0;
        chk({tag, "_rst_ready"}, bus.core_ready, 0);
        chk({tag, "_rst_outs"}, {bus.fproc_req_en, bus.busy, bus.req_overflow, bus.fproc_req_id, bus.core_data}, 0);
    endtask

    // Advance to the ISSUE cycle (bounded) and report the issued id.
    task automatic wait_issue(input string tag, output logic [IDW-1:0] id);
        int b = 0;
        while (!bus.fproc_req_en && b < 20) begin
            tick();
            b++;
        end
        chk({tag, "_issue_seen"}, bus.fproc_req_en, 1);
        id = bus.fproc_req_id;
    endtask

    // From ISSUE (or WAIT): ack after k cycles, sample the RESP cycle, optionally re-request there.
    task automatic finish_txn(input int k, input logic [DW-1:0] d, input logic [N-1:0] rr_en,
                              input logic [N*IDW-1:0] rr_ids, output logic [N-1:0] rdy,
                              output logic [DW-1:0] rdata, output int rcyc);
        repeat (k) tick();
        bus.fproc_ack  = 1'b1;
        bus.fproc_data = d;
        tick();
        bus.fproc_ack  = 1'b0;
        bus.fproc_data = '0;
        rdy   = bus.core_ready;
        rdata = bus.core_data;
        rcyc  = cyc;
        if (rr_en != '0) begin
            bus.core_req_en = rr_en;
            bus.core_req_id = rr_ids;
        end
        tick();
        clr_req();
    endtask

    initial begin
        logic [IDW-1:0] id;
        logic [N-1:0]   rdy;
        logic [DW-1:0]  rd;
        int             rc, prev_rc, t0, extra;
        logic           seen;

        // 1: single request, k=3
        do_reset("t1");
        set_req(2, 8'h15);
        t0 = cyc;
        tick();
        clr_req();
        chk("t1_no_issue_T1", bus.fproc_req_en, 0);
        tick();
        chk("t1_issue_T2", bus.fproc_req_en, 1);
        chk("t1_issue_id", bus.fproc_req_id, 8'h15);
        chk("t1_busy", bus.busy, 1);
        finish_txn(3, 32'hDEADBEEF, '0, '0, rdy, rd, rc);
        chk("t1_ready", rdy, 4'b0100);
        chk("t1_data", rd, 32'hDEADBEEF);
        chk("t1_ready_cycle", rc - t0, 6);
        chk("t1_busy_low_T7", bus.busy, 0);
        chk("t1_data_cleared", bus.core_data, 0);

        // 2: all cores at once, k=1
        do_reset("t2");
        for (int i = 0; i < N; i++) set_req(i, IDW'(i + 1));
        tick();
        clr_req();
        prev_rc = 0;
        for (int i = 0; i < N; i++) begin
            wait_issue("t2", id);
            chk($sformatf("t2_id%0d", i), id, i + 1);
            finish_txn(1, 32'hC0DE_0000 + i, '0, '0, rdy, rd, rc);
            chk($sformatf("t2_ready%0d", i), rdy, 4'b0001 << i);
            chk($sformatf("t2_data%0d", i), rd, 32'hC0DE_0000 + i);
            if (i > 0) chk($sformatf("t2_spacing%0d", i), rc - prev_rc, 4);
            prev_rc = rc;
        end

        // 3: rr_ptr=1, then cores 0 and 3 pending -> 3 first
        do_reset("t3");
        set_req(1, 8'h01);
        tick();
        clr_req();
        wait_issue("t3a", id);
        finish_txn(1, 32'h1111_0001, '0, '0, rdy, rd, rc);
        chk("t3_first_ready", rdy, 4'b0010);
        set_req(0, 8'h30);
        set_req(3, 8'h33);
        tick();
        clr_req();
        wait_issue("t3b", id);
        chk("t3_id_core3", id, 8'h33);
        finish_txn(1, 32'h3333_0003, '0, '0, rdy, rd, rc);
        chk("t3_ready_core3", rdy, 4'b1000);
        wait_issue("t3c", id);
        chk("t3_id_core0", id, 8'h30);
        finish_txn(1, 32'h3030_0000, '0, '0, rdy, rd, rc);
        chk("t3_ready_core0", rdy, 4'b0001);

        // 4: core 1 re-requests in its own RESP cycle
        do_reset("t4");
        set_req(1, 8'h21);
        tick();
        clr_req();
        wait_issue("t4a", id);
        chk("t4_id_first", id, 8'h21);
        finish_txn(1, 32'h2121_2121, 4'b0010, 32'h0000_2200, rdy, rd, rc);
        chk("t4_ready_first", rdy, 4'b0010);
        chk("t4_no_overflow", bus.req_overflow, 0);
        wait_issue("t4b", id);
        chk("t4_id_second", id, 8'h22);
        finish_txn(1, 32'h2222_2222, '0, '0, rdy, rd, rc);
        chk("t4_ready_second", rdy, 4'b0010);
        chk("t4_data_second", rd, 32'h2222_2222);
        chk("t4_no_overflow_end", bus.req_overflow, 0);

        // 5: core 0 requests twice while WAIT is blocked on core 2
        do_reset("t5");
        set_req(2, 8'h40);
        tick();
        clr_req();
        wait_issue("t5a", id);
        chk("t5_id_core2", id, 8'h40);
        tick();
        set_req(0, 8'h10);
        tick();
        chk("t5_no_overflow_first", bus.req_overflow, 0);
        set_req(0, 8'h11);
        tick();
        clr_req();
        chk("t5_overflow_set", bus.req_overflow, 1);
        finish_txn(1, 32'h4040_4040, '0, '0, rdy, rd, rc);
        chk("t5_ready_core2", rdy, 4'b0100);
        wait_issue("t5b", id);
        chk("t5_id_core0", id, 8'h11);
        finish_txn(1, 32'h1111_1111, '0, '0, rdy, rd, rc);
        chk("t5_ready_core0", rdy, 4'b0001);
        extra = 0;
        repeat (8) begin
            tick();
            if (bus.fproc_req_en) extra++;
        end
        chk("t5_no_reissue", extra, 0);
        chk("t5_overflow_sticky", bus.req_overflow, 1);

        // 6: reset during WAIT, late ack afterwards
        do_reset("t6");
        set_req(3, 8'h5A);
        tick();
        clr_req();
        wait_issue("t6", id);
        tick();
        chk("t6_busy_in_wait", bus.busy, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_async_clear", {bus.core_ready, bus.fproc_req_en, bus.busy, bus.core_data}, 0);
        tick();
        reset = 1'b0;
        bus.fproc_ack  = 1'b1;
        bus.fproc_data = 32'hFFFF_FFFF;
        tick();
        bus.fproc_ack  = 1'b0;
        bus.fproc_data = '0;
        seen = 1'b0;
        repeat (6) begin
            if ((bus.core_ready != '0) || bus.fproc_req_en || bus.busy) seen = 1'b1;
            tick();
        end
        chk("t6_late_ack_ignored", seen, 0);
        chk("t6_overflow_clear", bus.req_overflow, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fproc_rr_arbiter.md
Name: fproc_rr_arbiter

Overview:
- Shares the single function-processor (fproc) request channel among N_CORES processor cores. Each core's ctrl FSM issues a one-cycle fproc request and then waits for ready.
- The block latches the requests, serialises them to fproc in round-robin order, and returns the response data with a one-cycle ready pulse to the owning core.
- It sits between the per-core ctrl/fproc ports and the fproc block.

Parameters:
- N_CORES, 4, number of requesting cores (2..16).
- ID_WIDTH, 8, width of the fproc function id.
- DATA_WIDTH, 32, width of the fproc response data.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- core_req_en  in  N_CORES  per-core one-cycle request strobe (from ctrl fproc_out_ready).
- core_req_id  in  N_CORES*ID_WIDTH  per-core function id; core i occupies bits [i*ID_WIDTH +: ID_WIDTH]; sampled when core_req_en[i]=1.
- core_ready  out  N_CORES  one-hot, one-cycle response strobe (to ctrl fproc_ready).
- core_data  out  DATA_WIDTH  response data; valid when any core_ready bit is 1.
- fproc_req_en  out  1  one-cycle request strobe to fproc.
- fproc_req_id  out  ID_WIDTH  function id; valid with fproc_req_en.
- fproc_ack  in  1  fproc response valid.
- fproc_data  in  DATA_WIDTH  fproc response data; valid with fproc_ack.
- busy  out  1  high whenever state != IDLE.
- req_overflow  out  1  sticky flag: request arrived from a core that already had a request pending.

Behaviour:
- Reset (async, active-high):
  - state=IDLE; all pending bits and latched ids = 0.
  - rr_ptr=N_CORES-1, so core 0 wins first.
  - All outputs 0, including req_overflow.
  - Reset mid-transaction abandons the transaction. Any late fproc_ack after reset release is ignored, because it is only sampled in WAIT.
- Request capture:
  - On each clk where core_req_en[i]=1: pending[i]<=1 and id_q[i]<=core_req_id slice i.
  - If pending[i] was already 1 and is not being cleared that cycle: req_overflow<=1. id_q[i] is overwritten (last request wins).
  - Capture is independent of state. All cores may request in the same cycle.
- FSM, all transitions registered:
  - IDLE: if any pending bit is set, grant<=first pending index searching rr_ptr+1, rr_ptr+2, ... modulo N_CORES. Go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: fproc_req_en=1, fproc_req_id=id_q[grant], for exactly one cycle. Go to WAIT. fproc_ack is not sampled in this state.
  - WAIT: hold until fproc_ack=1. Then data_q<=fproc_data and go to RESP. No timeout; the block waits indefinitely.
  - RESP: core_ready[grant]=1 and core_data=data_q for one cycle. pending[grant] is cleared and rr_ptr<=grant. Go to IDLE.
- Simultaneous events:
  - In RESP, if core_req_en[grant]=1 in the same cycle, the set wins: pending stays 1, the new id is latched, and no overflow is flagged.
  - fproc_ack outside WAIT is ignored.
- Outputs:
  - fproc_req_en, core_ready, core_data and fproc_req_id are registered or decoded from registered state. There is no combinational path from inputs to outputs.
  - core_data and fproc_req_id are 0 when not valid.
- Latency (single request, idle system, fproc ack k cycles after fproc_req_en):
  - core_req_en at cycle T, so pending is seen at T+1 and fproc_req_en is high at T+2.
  - core_ready is high at T+2+k+1, with k>=1.
- Throughput: one transaction per (k+3) cycles. Fairness: each pending core is served within N_CORES transactions.

Decomposition:
- Package fproc_arb_pkg holds:
  - state encoding localparams: IDLE=0, ISSUE=1, WAIT=2, RESP=3, 2-bit state register;
  - a clog2-based index width helper.
- One natural sub-module: rr_pick. It is combinational and takes a pending vector and rr_ptr, returning a valid flag and the granted index. It is reusable by other arbiters in the design.
- The top level holds the pending/id registers, the FSM and the response register.

Test Plan:
- Reset, then core 2 requests id=0x15; fproc acks 3 cycles after request with 0xDEADBEEF -> fproc_req_en at T+2 with id 0x15; core_ready=4'b0100 and core_data=0xDEADBEEF at T+6; busy low at T+7.
- All 4 cores request in the same cycle (ids 1,2,3,4), ack k=1 -> fproc_req_id sequence 1,2,3,4; core_ready pulses in order 0,1,2,3, spaced 4 cycles apart.
- rr_ptr=1 after serving core 1; cores 0 and 3 then pending -> core 3 is served before core 0.
- Core 1 re-requests (id=0x22) in the RESP cycle of its own transaction -> pending is retained, req_overflow stays 0, and the next issue for core 1 carries 0x22.
- Core 0 requests twice (ids 0x10 then 0x11) while WAIT is blocked on another core -> req_overflow=1 (sticky); core 0 is later issued with id 0x11 only once.
- Assert reset during WAIT, then pulse fproc_ack after release -> all outputs 0, no core_ready pulse, state IDLE, pending cleared.
